seq_detector_mealy: RTL and testbench
=====================================

Name: seq_detector_mealy

Overview:
- Parametrised Mealy serial-pattern detector and the successor to the fixed two-state edge/sequence detectors in the processor front end.
- Watches one serial input bit per enabled cycle and compares it against a PATTERN_W-bit pattern that can be reloaded at run time.
- Asserts y combinationally in the same cycle the final pattern bit arrives.
- Supports overlapping and non-overlapping matches and keeps a saturating match counter for debug and status readout.

Parameters:
PATTERN_W, 4, pattern length in bits; legal range is 2 or more.
DEFAULT_PATTERN, 4'b1011, pattern value loaded at reset; width PATTERN_W.
COUNT_W, 8, match counter width; legal range is 1 or more.

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
en  input  1  sample enable; a is consumed only when en=1
a  input  1  serial data bit
overlap  input  1  1 = overlapping matches allowed; 0 = history cleared after each match
cfg_load  input  1  load pattern_in into the pattern register
pattern_in  input  PATTERN_W  new pattern; the first-received bit is the MSB
clr_count  input  1  synchronous clear of match_count and count_sat
y  output  1  Mealy match output
match_count  output  COUNT_W  number of matches, saturating
count_sat  output  1  1 when match_count is all-ones
pattern_q  output  PATTERN_W  current pattern register

Behaviour:
- Reset (reset_n=0, asynchronous):
  - hist cleared to 0; fill cleared to 0.
  - pattern_q = DEFAULT_PATTERN.
  - match_count = 0; count_sat = 0.
  - y = 0 for as long as reset_n=0.
- State:
  - hist: PATTERN_W-1 bits holding the most recently accepted bits; the newest bit is the LSB.
  - fill: counter 0..PATTERN_W-1 giving the number of valid history bits; it saturates at PATTERN_W-1.
- Output y (combinational, zero latency from a):
  - y = en and not cfg_load and (fill == PATTERN_W-1) and ({hist, a} == pattern_q).
- Next-state rules, in priority order:
  1. cfg_load=1: pattern_q <= pattern_in; hist <= 0; fill <= 0. The bit on a is discarded regardless of en, and y=0 that cycle.
  2. en=0: hist, fill and pattern hold; y=0.
  3. en=1 and y=1 and overlap=0: hist <= 0; fill <= 0. The next match needs PATTERN_W fresh bits.
  4. en=1 otherwise: hist <= {hist[PATTERN_W-3:0], a}; fill <= min(fill+1, PATTERN_W-1).
  - For PATTERN_W=2, hist is 1 bit and the shift reduces to hist <= a.
- overlap is sampled each cycle, and a change takes effect on the current cycle's match.
- Counter, updated on the clock edge after y:
  - clr_count=1: match_count <= 0 and count_sat <= 0. Clear wins over a simultaneous match.
  - else if y=1 and match_count is not all-ones: match_count increments.
  - count_sat <= (next match_count == all-ones).
  - The counter never wraps.
- Reset mid-sequence discards partial history; no stale match is possible afterwards.
- No X propagation: every register has a reset value, and y is defined whenever inputs are known.

Test Plan:
1. Reset with defaults -> y=0, match_count=0, count_sat=0, pattern_q=4'b1011. Assert reset_n mid-stream after 1,0,1 -> the next 1 alone gives y=0.
2. overlap=1, en=1, a = 1,0,1,1,0,1,1 over cycles 1-7 -> y=1 in cycles 4 and 7 only; match_count=2 after cycle 7's edge.
3. overlap=0, same stream -> y=1 in cycle 4 only; cycle 7 gives y=0 (only 3 fresh bits); match_count=1.
4. Enable gaps: a=1,0, then en=0 for 3 cycles with a toggling, then en=1 with a=1,1 -> y=1 on the final bit; y=0 throughout the en=0 cycles.
5. Reload: send 1,0,1, then cfg_load=1 with pattern_in=4'b0110 and a=1 -> y=0 and history cleared; then 0,1,1,0 -> y=1 on the 4th bit; 1,0,1,1 afterwards -> no match.
6. Counter, COUNT_W=2:
   - 4 overlapping matches -> match_count=3, count_sat=1, no wrap.
   - clr_count=1 in the same cycle as a match -> match_count=0, count_sat=0.
   - PATTERN_W=2 with pattern 2'b11 and stream 1,1,1 under overlap=1 -> y on bits 2 and 3.

Source files
------------

// File: rtl/seq_detector_mealy.sv
// seq_detector_mealy: Mealy serial-pattern detector with a run-time reloadable pattern,
// overlapping/non-overlapping matching and a saturating match counter.
module seq_detector_mealy #(
  parameter int PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = 4'b1011,
  parameter int COUNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 a,
  input  logic                 overlap,
  input  logic                 cfg_load,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic                 clr_count,
  output logic                 y,
  output logic [COUNT_W-1:0]   match_count,
  output logic                 count_sat,
  output logic [PATTERN_W-1:0] pattern_q
);
  localparam int FW = $clog2(PATTERN_W);
  localparam logic [FW-1:0] FULL = FW'(PATTERN_W - 1);
  logic [PATTERN_W-2:0] hist, hist_d;
  logic [FW-1:0]        fill, fill_d;
  logic [PATTERN_W-1:0] pattern_d, win;
  logic [COUNT_W-1:0]   count_d;
  logic                 flush;
  // win is the candidate pattern; its low bits are also the shifted history
  always_comb begin
    win       = {hist, a};
    y         = en && !cfg_load && fill == FULL && win == pattern_q;
    flush     = cfg_load || (y && !overlap);
    pattern_d = cfg_load ? pattern_in : pattern_q;
    hist_d    = flush ? '0 : en ? win[PATTERN_W-2:0] : hist;
    fill_d    = flush ? '0 : (en && fill != FULL) ? fill + 1'b1 : fill;
    count_d   = clr_count ? '0 : (y && !(&match_count)) ? match_count + 1'b1 : match_count;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist        <= '0;
      fill        <= '0;
      pattern_q   <= DEFAULT_PATTERN;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      hist        <= hist_d;
      fill        <= fill_d;
      pattern_q   <= pattern_d;
      match_count <= count_d;
      count_sat   <= &count_d;
    end
  end
endmodule

// File: tb/tb_seq_detector_mealy.sv
// tb_seq_detector_mealy: directed scoreboard bench for seq_detector_mealy; the driver queues
// hand-computed expectations and a negedge monitor pops and compares them.
module tb_seq_detector_mealy;
  logic clk = 0, reset_n = 0, en = 0, a = 0, overlap = 0, cfg_load = 0, clr_count = 0;
  logic [3:0] pattern_in = 4'b0110;
  logic [1:0] pattern_in_p = 2'b11;
  logic y0, y1, y2, sat0, sat1, sat2;
  logic [7:0] mc0, mc2;
  logic [1:0] mc1;
  logic [3:0] pq0, pq1;
  logic [1:0] pq2;
  int checks = 0, errors = 0, tag = 0, id_g = 0;

  typedef struct {
    int id;
    bit ey;
    int ecnt;
    int esat;
    int epat;
    int tag;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  seq_detector_mealy dut (.clk(clk), .reset_n(reset_n), .en(en), .a(a), .overlap(overlap),
    .cfg_load(cfg_load), .pattern_in(pattern_in), .clr_count(clr_count), .y(y0),
    .match_count(mc0), .count_sat(sat0), .pattern_q(pq0));
  seq_detector_mealy #(.COUNT_W(2)) dut_c (.clk(clk), .reset_n(reset_n), .en(en), .a(a),
    .overlap(overlap), .cfg_load(cfg_load), .pattern_in(pattern_in), .clr_count(clr_count),
    .y(y1), .match_count(mc1), .count_sat(sat1), .pattern_q(pq1));
  seq_detector_mealy #(.PATTERN_W(2), .DEFAULT_PATTERN(2'b11)) dut_p (.clk(clk),
    .reset_n(reset_n), .en(en), .a(a), .overlap(overlap), .cfg_load(cfg_load),
    .pattern_in(pattern_in_p), .clr_count(clr_count), .y(y2), .match_count(mc2),
    .count_sat(sat2), .pattern_q(pq2));

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic gy;
      int gc, gs;
      e = sb.pop_front();
      gy = e.id == 0 ? y0 : e.id == 1 ? y1 : y2;
      gc = e.id == 0 ? int'(mc0) : e.id == 1 ? int'(mc1) : int'(mc2);
      gs = e.id == 0 ? int'(sat0) : e.id == 1 ? int'(sat1) : int'(sat2);
      checks++;
      if (gy !== e.ey) begin
        errors++;
        $display("FAIL y step %0d dut %0d: got %0b want %0b", e.tag, e.id, gy, e.ey);
      end
      if (e.ecnt >= 0) begin
        checks++;
        if (gc != e.ecnt) begin
          errors++;
          $display("FAIL match_count step %0d dut %0d: got %0d want %0d", e.tag, e.id, gc, e.ecnt);
        end
      end
      if (e.esat >= 0) begin
        checks++;
        if (gs != e.esat) begin
          errors++;
          $display("FAIL count_sat step %0d dut %0d: got %0d want %0d", e.tag, e.id, gs, e.esat);
        end
      end
      if (e.epat >= 0) begin
        checks++;
        if (int'(pq0) != e.epat) begin
          errors++;
          $display("FAIL pattern_q step %0d: got %b want %b", e.tag, pq0, e.epat[3:0]);
        end
      end
    end
  end

  task automatic step(input bit r, input bit e_, input bit av, input bit ld, input bit clr,
                      input bit ey, input int ecnt, input int esat, input int epat);
    @(posedge clk);
    #1;
    reset_n = !r;
    en = e_;
    a = av;
    cfg_load = ld;
    clr_count = clr;
    sb.push_back('{id_g, ey, ecnt, esat, epat, tag});
    tag++;
  endtask

  task automatic b(input bit av, input bit ey, input int ec = -1, input int es = -1);
    step(0, 1, av, 0, 0, ey, ec, es, -1);
  endtask

  task automatic g(input bit av);
    step(0, 0, av, 0, 0, 0, -1, -1, -1);
  endtask

  task automatic idle(input int ec, input int es);
    step(0, 0, 0, 0, 0, 0, ec, es, -1);
  endtask

  task automatic rst();
    step(1, 0, 0, 0, 0, 0, 0, 0, -1);
  endtask

  initial begin
    // reset values, then a reset in the middle of 1,0,1 leaves no stale history
    id_g = 0;
    overlap = 1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 'b1011);
    b(1, 0); b(0, 0); b(1, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, -1);
    b(1, 0, 0, 0);
    // overlapping matches
    rst();
    b(1, 0, 0, 0); b(0, 0, 0); b(1, 0, 0); b(1, 1, 0, 0);
    b(0, 0, 1); b(1, 0, 1); b(1, 1, 1, 0);
    idle(2, 0);
    // non-overlapping: cycle 7 has only three fresh bits
    rst();
    overlap = 0;
    b(1, 0, 0); b(0, 0, 0); b(1, 0, 0); b(1, 1, 0);
    b(0, 0, 1); b(1, 0, 1); b(1, 0, 1);
    idle(1, 0);
    // enable gaps
    rst();
    overlap = 1;
    b(1, 0); b(0, 0);
    g(1); g(0); g(1);
    b(1, 0, 0); b(1, 1, 0);
    idle(1, 0);
    // pattern reload discards the pending bit and history
    rst();
    b(1, 0); b(0, 0); b(1, 0);
    step(0, 1, 1, 1, 0, 0, -1, -1, 'b1011);
    step(0, 1, 0, 0, 0, 0, 0, 0, 'b0110);
    b(1, 0); b(1, 0); b(0, 1, 0);
    b(1, 0, 1); b(0, 0); b(1, 0); b(1, 0, 1);
    idle(1, 0);
    // 2-bit counter saturates at 3 and clear beats a simultaneous match
    id_g = 1;
    rst();
    b(1, 0, 0); b(0, 0, 0); b(1, 0, 0); b(1, 1, 0, 0);
    b(0, 0, 1); b(1, 0, 1); b(1, 1, 1, 0);
    b(0, 0, 2); b(1, 0, 2); b(1, 1, 2, 0);
    b(0, 0, 3, 1); b(1, 0, 3, 1); b(1, 1, 3, 1);
    idle(3, 1);
    b(0, 0, 3, 1); b(1, 0, 3, 1);
    step(0, 1, 1, 0, 1, 1, 3, 1, -1);
    idle(0, 0);
    // two-bit pattern 11, overlapping
    id_g = 2;
    rst();
    b(1, 0, 0, 0); b(1, 1, 0, 0); b(1, 1, 1, 0);
    idle(2, 0);
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
